// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver.
// Holds the FSM state encoding, the oversampling sample points and the
// default frame geometry. The build macro UART_RX_PARITY_EN (used in uart_rx)
// adds the PARITY state to the frame. The state value is reserved here in
// every build.
package uart_pkg;

    // Default frame geometry: data bits per frame and ticks per stop bit.
    localparam int DEFAULT_DBIT    = 8;
    localparam int DEFAULT_SB_TICK = 16;

    // Tick count at which the start bit is re-checked. This is the middle of the bit.
    localparam logic [3:0] START_MID   = 4'd7;

    // Tick count at which a data or parity bit is sampled. This is one full bit
    // period after the previous sample point.
    localparam logic [3:0] LAST_SAMPLE = 4'd15;

    // Receiver FSM states.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous input.
// Both flops reset to 1 so that an idle-high serial line never produces a
// false start edge when reset is released.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // Two back-to-back flops give the first stage time to settle before
    // the second stage uses its value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver that uses 16x oversampling.
// The receiver synchronizes Rx and finds the falling start edge. It re-checks
// the start bit in the middle of the bit, then samples each data bit one bit
// period apart, LSB first, and checks the stop bit. At the end of a frame it
// sends a one-cycle RxDone pulse together with FrameErr and ParityErr.
// Build macro UART_RX_PARITY_EN: when this macro is defined, an even-parity bit
// follows the data bits. When it is not defined, the PARITY state is never
// entered and ParityErr stays 0.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DBIT    = DEFAULT_DBIT,
    parameter int SB_TICK = DEFAULT_SB_TICK
) (
    input  logic            Clk,
    input  logic            Rst_n,
    input  logic            Tick,
    input  logic            Rx,
    output logic [DBIT-1:0] RxData,
    output logic            RxDone,
    output logic            FrameErr,
    output logic            ParityErr,
    output logic            Busy
);

    localparam int              NW        = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam logic [NW-1:0]   N_LAST    = NW'(DBIT - 1);
    localparam logic [3:0]      STOP_LAST = 4'(SB_TICK - 1);

    logic            rx_s;

    state_t          state_q,  state_d;
    logic [3:0]      s_q,      s_d;
    logic [NW-1:0]   n_q,      n_d;
    logic [DBIT-1:0] shreg_q,  shreg_d;
    logic [DBIT-1:0] data_q,   data_d;
    logic            done_q,   done_d;
    logic            ferr_q,   ferr_d;
    logic            perr_q,   perr_d;
`ifdef UART_RX_PARITY_EN
    logic            par_bad_q, par_bad_d;
`endif

    sync2 u_sync_rx (
        .clk (Clk),
        .rst (Rst_n),
        .d   (Rx),
        .q   (rx_s)
    );

    // Compute the next state. s, n and state change only on Tick. The one
    // exception is the start-edge detection in IDLE, which is checked on every clock.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
        perr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
`endif
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    s_d     = 4'd0;
                end
            end
            START: begin
                if (Tick) begin
                    if (s_q == START_MID) begin
                        s_d = 4'd0;
                        if (!rx_s) begin
                            state_d = DATA;
                            n_d     = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            DATA: begin
                if (Tick) begin
                    if (s_q == LAST_SAMPLE) begin
                        shreg_d = DBIT'({rx_s, shreg_q} >> 1);
                        s_d     = 4'd0;
                        if (n_q == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            n_d = n_q + NW'(1);
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (Tick) begin
                    if (s_q == LAST_SAMPLE) begin
                        par_bad_d = (^shreg_q) ^ rx_s;
                        s_d       = 4'd0;
                        state_d   = STOP;
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
`endif
            STOP: begin
                if (Tick) begin
                    if (s_q == STOP_LAST) begin
                        data_d  = shreg_q;
                        done_d  = 1'b1;
                        ferr_d  = ~rx_s;
`ifdef UART_RX_PARITY_EN
                        perr_d  = par_bad_q;
`endif
                        s_d     = 4'd0;
                        state_d = IDLE;
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                s_d     = 4'd0;
            end
        endcase
    end

    // Register the FSM, the counters, the shift register and the frame-end outputs.
    always_ff @(posedge Clk or posedge Rst_n) begin
        if (Rst_n) begin
            state_q <= IDLE;
            s_q     <= 4'd0;
            n_q     <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
            perr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
            perr_q  <= perr_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= par_bad_d;
`endif
        end
    end

    assign RxData    = data_q;
    assign RxDone    = done_q;
    assign FrameErr  = ferr_q;
    assign ParityErr = perr_q;
    assign Busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx.
// The bench sends serial frames aligned to a Tick that occurs every 4 clocks.
// The expected result of each frame goes into a queue. A monitor compares each
// RxDone pulse with the expected result at the head of the queue.
// UART_RX_PARITY_EN adds a parity bit to every frame the bench sends.
module tb_uart_rx;

    localparam int DBIT = 8;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN  = 1'b1;
    localparam int FRAME_T = 168;
`else
    localparam bit PAR_EN  = 1'b0;
    localparam int FRAME_T = 152;
`endif

    logic            Clk   = 1'b0;
    logic            Rst_n = 1'b1;
    logic            Tick  = 1'b0;
    logic            Rx    = 1'b1;
    logic [DBIT-1:0] RxData;
    logic            RxDone;
    logic            FrameErr;
    logic            ParityErr;
    logic            Busy;

    typedef struct {
        logic [7:0] data;
        bit         ferr;
        bit         perr;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        bit         stop_low;
        bit         par_bad;
        logic [7:0] exp_data;
        bit         exp_ferr;
    } vec_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    int   done_cnt  = 0;
    int   sent_cnt  = 0;
    int   stray     = 0;
    bit   prev_done = 1'b0;

    uart_rx #(.DBIT(DBIT), .SB_TICK(16)) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .Tick      (Tick),
        .Rx        (Rx),
        .RxData    (RxData),
        .RxDone    (RxDone),
        .FrameErr  (FrameErr),
        .ParityErr (ParityErr),
        .Busy      (Busy)
    );

    always #5 Clk = ~Clk;

    // Tick is high for one full clock out of every four.
    initial begin : tick_gen
        int cnt;
        cnt = 0;
        forever begin
            @(negedge Clk);
            Tick = (cnt == 3);
            cnt  = (cnt + 1) % 4;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    // Wait for n ticks. The task returns on the falling edge after the last tick.
    task automatic waitTicks(input int n);
        repeat (n) begin
            do @(posedge Clk); while (!Tick);
            @(negedge Clk);
        end
    endtask

    task automatic driveBit(input logic b, input int ticks);
        Rx = b;
        waitTicks(ticks);
    endtask

    // Send one frame and queue its expected result. A frame with a low stop bit
    // holds the line low past the stop sample point, then returns the line to idle.
    task automatic applyStimulus(input logic [7:0] data, input bit stop_low, input bit par_bad,
                                 input logic [7:0] exp_data, input bit exp_ferr);
        exp_t e;
        e.data = exp_data;
        e.ferr = exp_ferr;
        e.perr = PAR_EN ? par_bad : 1'b0;
        exp_q.push_back(e);
        sent_cnt++;
        driveBit(1'b0, 16);
        for (int i = 0; i < 8; i++) driveBit(data[i], 16);
`ifdef UART_RX_PARITY_EN
        driveBit((^data) ^ par_bad, 16);
`endif
        if (stop_low) begin
            driveBit(1'b0, 10);
            driveBit(1'b1, 16);
        end else begin
            driveBit(1'b1, 16);
        end
    endtask

    // Scoreboard: compare every RxDone pulse with the oldest queued expectation.
    // Also count flags raised outside RxDone and RxDone pulses longer than one clock.
    always @(negedge Clk) begin
        if (RxDone) begin
            done_cnt++;
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                checkOutput("rx_data",    32'(RxData),    32'(mon_e.data));
                checkOutput("frame_err",  32'(FrameErr),  32'(mon_e.ferr));
                checkOutput("parity_err", 32'(ParityErr), 32'(mon_e.perr));
            end else begin
                stray++;
            end
        end else if (FrameErr || ParityErr) begin
            stray++;
        end
        if (RxDone && prev_done) stray++;
        prev_done = RxDone;
    end

    initial begin : main
        vec_t vecs[7];
        logic [7:0] rdata;
        bit         rstop;
        bit         rpar;

        vecs[0] = '{data: 8'hA5, stop_low: 1'b0, par_bad: 1'b0, exp_data: 8'hA5, exp_ferr: 1'b0};
        vecs[1] = '{data: 8'h3C, stop_low: 1'b1, par_bad: 1'b0, exp_data: 8'h3C, exp_ferr: 1'b1};
        vecs[2] = '{data: 8'h00, stop_low: 1'b0, par_bad: 1'b0, exp_data: 8'h00, exp_ferr: 1'b0};
        vecs[3] = '{data: 8'hFF, stop_low: 1'b0, par_bad: 1'b0, exp_data: 8'hFF, exp_ferr: 1'b0};
        vecs[4] = '{data: 8'h55, stop_low: 1'b0, par_bad: 1'b0, exp_data: 8'h55, exp_ferr: 1'b0};
        vecs[5] = '{data: 8'h01, stop_low: 1'b0, par_bad: 1'b0, exp_data: 8'h01, exp_ferr: 1'b0};
        vecs[6] = '{data: 8'h80, stop_low: 1'b0, par_bad: 1'b0, exp_data: 8'h80, exp_ferr: 1'b0};

        // Reset state.
        repeat (5) @(negedge Clk);
        checkOutput("reset_rxdata",    32'(RxData),    32'h0);
        checkOutput("reset_rxdone",    32'(RxDone),    32'h0);
        checkOutput("reset_frameerr",  32'(FrameErr),  32'h0);
        checkOutput("reset_parityerr", 32'(ParityErr), 32'h0);
        checkOutput("reset_busy",      32'(Busy),      32'h0);
        Rst_n = 1'b0;
        waitTicks(4);

        // Table frames. Frames 2 to 6 are sent back to back (0x00, 0xFF, 0x55, ...).
        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].data, vecs[i].stop_low, vecs[i].par_bad,
                          vecs[i].exp_data, vecs[i].exp_ferr);
            checkOutput($sformatf("frames_seen_vec%0d", i), 32'(done_cnt), 32'(sent_cnt));
            checkOutput($sformatf("busy_after_vec%0d", i), 32'(Busy), 32'h0);
        end

        // A short low pulse is rejected as a glitch.
        driveBit(1'b0, 3);
        checkOutput("busy_in_start", 32'(Busy), 32'h1);
        driveBit(1'b1, 12);
        checkOutput("glitch_busy", 32'(Busy), 32'h0);
        checkOutput("glitch_no_done", 32'(done_cnt), 32'(sent_cnt));

        // Reset during data bit 4 of 0x81 aborts that frame. A clean 0x7E follows.
        driveBit(1'b0, 16);
        for (int i = 0; i < 4; i++) driveBit(((8'h81 >> i) & 8'h01) != 0, 16);
        driveBit(1'b0, 8);
        checkOutput("busy_mid_frame", 32'(Busy), 32'h1);
        Rst_n = 1'b1;
        Rx    = 1'b1;
        repeat (3) @(negedge Clk);
        checkOutput("busy_in_reset", 32'(Busy), 32'h0);
        Rst_n = 1'b0;
        waitTicks(20);
        checkOutput("rxdata_after_reset", 32'(RxData), 32'h0);
        checkOutput("aborted_no_done", 32'(done_cnt), 32'(sent_cnt));
        applyStimulus(8'h7E, 1'b0, 1'b0, 8'h7E, 1'b0);
        checkOutput("frames_after_reset", 32'(done_cnt), 32'(sent_cnt));

        // A break (line held low) produces back-to-back framing-error frames.
        // The second frame is accepted right after the first RxDone.
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back('{data: 8'h00, ferr: 1'b1, perr: 1'b0});
            sent_cnt++;
        end
        driveBit(1'b0, 2 * FRAME_T + 6);
        driveBit(1'b1, 20);
        checkOutput("break_frames", 32'(done_cnt), 32'(sent_cnt));
        checkOutput("break_busy", 32'(Busy), 32'h0);

`ifdef UART_RX_PARITY_EN
        // Parity for 0x07: a parity bit of 0 is an error, and a parity bit of 1 is correct.
        applyStimulus(8'h07, 1'b0, 1'b1, 8'h07, 1'b0);
        applyStimulus(8'h07, 1'b0, 1'b0, 8'h07, 1'b0);
        checkOutput("parity_frames", 32'(done_cnt), 32'(sent_cnt));
`endif

        // Random frames with random stop errors, random parity errors and random gaps.
        for (int i = 0; i < 15; i++) begin
            rdata = 8'($urandom);
            rstop = ($urandom_range(0, 3) == 0);
            rpar  = 1'($urandom_range(0, 1));
            applyStimulus(rdata, rstop, rpar, rdata, rstop);
            waitTicks($urandom_range(0, 12));
        end
        waitTicks(4);
        checkOutput("random_frames", 32'(done_cnt), 32'(sent_cnt));
        checkOutput("queue_empty", 32'(exp_q.size()), 32'h0);
        checkOutput("stray_flags", 32'(stray), 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter DBIT, default 8, meaning number of data bits per frame.
REQ-002 Parameter SB_TICK, default 16, meaning Tick count spanning one stop bit.
REQ-003 Clk  input  1  system clock (100 MHz); all state changes on posedge Clk.
REQ-004 Rst_n  input  1  reset; asynchronous, active-high.
REQ-005 Tick  input  1  16x-baud oversampling strobe from the baud-rate generator, one Clk wide.
REQ-006 Rx  input  1  serial line, idle high, asynchronous to Clk.
REQ-007 RxData  output  DBIT  last received data byte, LSB received first.
REQ-008 RxDone  output  1  one-Clk pulse marking RxData valid.
REQ-009 FrameErr  output  1  high in the RxDone cycle if the stop bit sampled low.
REQ-010 ParityErr  output  1  high in the RxDone cycle on parity mismatch (see Configuration).
REQ-011 Busy  output  1  high in every state except IDLE.

Function
REQ-012 Rx SHALL pass a 2-flop synchronizer; all decisions use the synchronized value (rx_s).
REQ-013 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; a 4-bit tick counter s and a bit counter n (clog2(DBIT) bits) SHALL be kept.
REQ-014 IDLE: rx_s==0 -> START, s<=0; otherwise stay.
REQ-015 START: on Tick with s==7 (mid start bit) -> DATA with s<=0,n<=0 if rx_s==0, else IDLE (glitch rejected); other Ticks s<=s+1.
REQ-016 DATA: on Tick with s==15 SHALL shift rx_s into the MSB of the shift register (right-shift), s<=0; when n==DBIT-1 -> PARITY (macro defined) or STOP, else n<=n+1.
REQ-017 STOP: on Tick with s==SB_TICK-1 SHALL sample rx_s, load RxData from the shift register, assert RxDone, set FrameErr=~rx_s, -> IDLE.
REQ-018 RxDone, FrameErr, ParityErr SHALL be registered and high exactly one Clk, the cycle after the stop-sampling Tick; all three 0 otherwise.
REQ-019 RxData SHALL hold its value between frames and update only with RxDone, including framing-error frames.
REQ-020 Clocks without Tick SHALL not change s, n or state (except IDLE->START detection).
REQ-021 A low line persisting after a framing error SHALL re-enter START from IDLE on the next cycle (break reception produces back-to-back frame errors).
REQ-022 Minimum detected end-to-start gap: a new start edge SHALL be accepted the first Clk after RxDone.

Reset
REQ-023 Reset SHALL force state IDLE, s=0, n=0, shift register=0, RxData=0, RxDone=0, FrameErr=0, ParityErr=0, Busy=0, synchronizer flops=1.
REQ-024 Reset mid-frame SHALL abort the frame with no RxDone; reception resumes on the next start edge after release.

Configuration
REQ-025 Macro UART_RX_PARITY_EN defined: PARITY state present; on Tick with s==15 sample parity bit, ParityErr=(^data)^rx_s (even parity), s<=0 -> STOP.
REQ-026 Macro undefined: PARITY state unreachable/removed, DATA goes straight to STOP, ParityErr tied 0, port retained.

Structure
REQ-027 Package uart_pkg SHALL hold the state encoding, START mid-sample constant (7), last-sample constant (15) and default DBIT/SB_TICK.
REQ-028 Sub-module sync2 (2-flop synchronizer, reset value 1) SHALL be instantiated for Rx; all else in uart_rx.

Verification
REQ-029 Tick every 4 Clk, send 8N1 0xA5 -> RxData=0xA5, RxDone one Clk, FrameErr=0, Busy low afterwards.
REQ-030 Rx low pulse of 3 Ticks then high -> return to IDLE, no RxDone.
REQ-031 Frame 0x3C with stop bit low -> RxData=0x3C, RxDone=1, FrameErr=1 same cycle.
REQ-032 Back-to-back frames 0x00, 0xFF, 0x55 with no idle gap -> three RxDone pulses, correct bytes in order.
REQ-033 Rst_n asserted at data bit 4 of 0x81, then clean 0x7E -> only one RxDone, RxData=0x7E.
REQ-034 With UART_RX_PARITY_EN, send 0x07 with parity bit 0 -> ParityErr=1; with parity bit 1 -> ParityErr=0.
